// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Holds the FSM state enum and the round-robin pick function.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_GAP
    } arb_state_t;

    localparam int MAX_REQ = 8;

    // One-hot of the first set request at/after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int                 idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client/TX bundle of the UART TX arbiter.
// slave: arbiter side; master: clients plus TX core side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ack;
    logic                 err;
    logic                 busy;
    logic                 tx_newd;
    logic [7:0]           tx_data;
    logic                 tx_done;

    modport slave (
        input  req, req_data, tx_done,
        output gnt, ack, err, busy,
        output tx_newd, tx_data
    );

    modport master (
        output req, req_data, tx_done,
        input  gnt, ack, err, busy,
        input  tx_newd, tx_data
    );
endinterface

// File: rtl/uart_rr_sel.sv
// Combinational round-robin selector.
// i_req, i_ptr -> o_gnt (one-hot), o_idx, o_vld.
module uart_rr_sel
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDXW-1:0]    o_idx,
    output logic               o_vld
);
    logic [MAX_REQ-1:0] w_req;
    logic [MAX_REQ-1:0] w_pick;

    always_comb begin
        w_req              = '0;
        w_req[NUM_REQ-1:0] = i_req;
        w_pick = rr_pick(w_req, 3'(i_ptr), NUM_REQ);
        o_gnt  = w_pick[NUM_REQ-1:0];
        o_idx  = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (w_pick[i]) o_idx = IDXW'(i);
        end
        o_vld = |i_req;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NUM_REQ clients.
// Ports: clk, rst (sync, active-high), bus (uart_tx_arbiter_if.slave).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 40000,
    parameter int GAP_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int WDW  = $clog2(TIMEOUT + 1);
    localparam int GW   = $clog2(GAP_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX   = '1;
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

    arb_state_t         r_state, w_state;
    logic [NUM_REQ-1:0] r_gnt, w_gnt;
    logic [NUM_REQ-1:0] r_ack, w_ack;
    logic [IDXW-1:0]    r_idx, w_idx;
    logic [IDXW-1:0]    r_ptr, w_ptr;
    logic [WDW-1:0]     r_wdog, w_wdog;
    logic [GW-1:0]      r_gap, w_gap;
    logic [7:0]         r_data, w_data;
    logic               r_err, w_err;
    logic               r_newd, w_newd;
    logic               r_done_q;

    logic [NUM_REQ-1:0] w_sel_gnt;
    logic [IDXW-1:0]    w_sel_idx;
    logic               w_sel_vld;
    logic               w_done_rise;
    logic [IDXW-1:0]    w_ptr_nxt;

    uart_rr_sel #(.NUM_REQ(NUM_REQ)) u_sel (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_sel_gnt),
        .o_idx (w_sel_idx),
        .o_vld (w_sel_vld)
    );

    assign w_done_rise = bus.tx_done & ~r_done_q;
    assign w_ptr_nxt = (r_idx == IDXW'(NUM_REQ - 1))
                     ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_idx   = r_idx;
        w_ack   = '0;
        w_err   = 1'b0;
        w_newd  = r_newd;
        w_data  = r_data;
        w_ptr   = r_ptr;
        w_wdog  = r_wdog;
        w_gap   = r_gap;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_sel_vld) begin
                    w_state = ARB_SEND;
                    w_gnt   = w_sel_gnt;
                    w_idx   = w_sel_idx;
                    w_data  = bus.req_data[8*w_sel_idx +: 8];
                    w_newd  = 1'b1;
                    w_wdog  = '0;
                end
            end
            ARB_SEND: begin
                if (r_wdog != WD_MAX) w_wdog = r_wdog + 1'b1;
                // Completion beats the watchdog in the same cycle.
                if (w_done_rise || r_wdog == WD_LAST) begin
                    w_state = ARB_GAP;
                    w_newd  = 1'b0;
                    w_gnt   = '0;
                    w_ptr   = w_ptr_nxt;
                    w_gap   = '0;
                    if (w_done_rise) w_ack = r_gnt;
                    else             w_err = 1'b1;
                end
            end
            ARB_GAP: begin
                // TX must see newd low while idle before the next grant.
                if (bus.tx_done) begin
                    w_gap = '0;
                end else if (r_gap == GAP_LAST) begin
                    w_state = ARB_IDLE;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            default: w_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_gnt    <= '0;
            r_idx    <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_newd   <= 1'b0;
            r_data   <= 8'h00;
            r_ptr    <= '0;
            r_wdog   <= '0;
            r_gap    <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_idx    <= w_idx;
            r_ack    <= w_ack;
            r_err    <= w_err;
            r_newd   <= w_newd;
            r_data   <= w_data;
            r_ptr    <= w_ptr;
            r_wdog   <= w_wdog;
            r_gap    <= w_gap;
            r_done_q <= bus.tx_done;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.ack     = r_ack;
    assign bus.err     = r_err;
    assign bus.busy    = (r_state != ARB_IDLE);
    assign bus.tx_newd = r_newd;
    assign bus.tx_data = r_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a UART TX model and serial RX.
// 1 MHz clock, 9600 baud, directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 2000;
    localparam int GAPC = 4;
    localparam int BAUD = 104;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_rst = 1'b1;
    logic tie0 = 1'b0;

    always #500 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .TIMEOUT    (TO),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // TX core model: accepts newd only after seeing it low while idle.
    int         m_st = 0;
    int         m_cnt = 0;
    int         m_bit = 0;
    logic [9:0] m_sh = '0;
    logic       m_done = 1'b0;
    logic       m_arm = 1'b0;
    logic       txd = 1'b1;
    int         sends = 0;

    assign bus.tx_done = m_done & ~tie0;

    always @(posedge clk) begin
        if (tx_rst) begin
            m_st <= 0; m_cnt <= 0; m_bit <= 0;
            m_done <= 1'b0; m_arm <= 1'b0; txd <= 1'b1;
        end else begin
            case (m_st)
                0: begin
                    if (bus.tx_newd && m_arm) begin
                        m_sh  <= {1'b1, bus.tx_data, 1'b0};
                        txd   <= 1'b0;
                        m_st  <= 1;
                        m_cnt <= 0;
                        m_bit <= 0;
                        m_arm <= 1'b0;
                    end else if (!bus.tx_newd) begin
                        m_arm <= 1'b1;
                    end
                end
                1: begin
                    if (m_cnt == BAUD - 1) begin
                        m_cnt <= 0;
                        if (m_bit == 9) begin
                            m_st   <= 2;
                            m_done <= 1'b1;
                            txd    <= 1'b1;
                        end else begin
                            m_bit <= m_bit + 1;
                            txd   <= m_sh[m_bit+1];
                        end
                    end else m_cnt <= m_cnt + 1;
                end
                default: begin
                    if (m_cnt == BAUD - 1) begin
                        m_cnt  <= 0;
                        m_done <= 1'b0;
                        m_st   <= 0;
                    end else m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) sends <= 0;
        else if (!tx_rst && m_st == 0 && m_arm && bus.tx_newd)
            sends <= sends + 1;
    end

    // Serial RX on the TX line.
    logic [7:0] rx_q[$];
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd);
            repeat (BAUD + BAUD/2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                b[i] = txd;
                repeat (BAUD) @(posedge clk);
            end
            rx_q.push_back(b);
        end
    end

    // Pulse counters, sampled before the edge updates them.
    int ack_cnt[NREQ];
    int err_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
            err_cnt = 0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (bus.ack[i] === 1'b1) ack_cnt[i]++;
            if (bus.err === 1'b1) err_cnt++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h100;
        chk(tag, got, {24'h0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        tie0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic wait_ack(input int idx, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ack[idx] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ack%0d_seen", idx), 32'(n < budget), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_seen", 32'(n < budget), 1);
    endtask

    task automatic wait_tx_idle(input int budget);
        int n;
        n = 0;
        while ((m_st != 0 || m_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("txidle_seen", 32'(n < budget), 1);
    endtask

    initial begin
        int n;
        bus.req = '0;
        bus.req_data = '0;
        repeat (2) @(negedge clk);
        tx_rst = 1'b0;
        do_reset();

        // Reset state
        chk("rst_gnt",  32'(bus.gnt), 0);
        chk("rst_ack",  32'(bus.ack), 0);
        chk("rst_err",  32'(bus.err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_newd", 32'(bus.tx_newd), 0);
        chk("rst_data", 32'(bus.tx_data), 0);

        // 1: single request, client 2
        bus.req_data[23:16] = 8'hA5;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t1_gnt",  32'(bus.gnt), 32'h4);
        chk("t1_newd", 32'(bus.tx_newd), 1);
        chk("t1_data", 32'(bus.tx_data), 32'hA5);
        chk("t1_busy", 32'(bus.busy), 1);
        wait_ack(2, 3000);
        bus.req = '0;
        @(negedge clk);
        chk("t1_ackpulse", 32'(bus.ack), 0);
        chk("t1_gap_gnt", 32'(bus.gnt), 0);
        wait_idle(400);
        chk_rx("t1_rx", 8'hA5);
        chk("t1_ackcnt", 32'(ack_cnt[2]), 1);
        chk("t1_sends", 32'(sends), 1);

        // 2: all four requesting, strict rotation
        do_reset();
        bus.req_data = 32'h44332211;
        bus.req = 4'b1111;
        wait_ack(0, 3000);
        wait_ack(1, 3000);
        wait_ack(2, 3000);
        wait_ack(3, 3000);
        wait_ack(0, 3000);
        bus.req = '0;
        @(negedge clk);
        wait_idle(400);
        chk_rx("t2_rx0", 8'h11);
        chk_rx("t2_rx1", 8'h22);
        chk_rx("t2_rx2", 8'h33);
        chk_rx("t2_rx3", 8'h44);
        chk_rx("t2_rx4", 8'h11);
        chk("t2_ack0", 32'(ack_cnt[0]), 2);
        chk("t2_ack1", 32'(ack_cnt[1]), 1);
        chk("t2_ack2", 32'(ack_cnt[2]), 1);
        chk("t2_ack3", 32'(ack_cnt[3]), 1);

        // 3: pointer at 2 wraps to client 0
        do_reset();
        bus.req_data = 32'h00005A0F;
        bus.req = 4'b0010;
        wait_ack(1, 3000);
        bus.req = '0;
        @(negedge clk);
        wait_idle(400);
        bus.req = 4'b0011;
        @(negedge clk);
        chk("t3_wrap_gnt", 32'(bus.gnt), 32'h1);
        wait_ack(0, 3000);
        bus.req = '0;
        @(negedge clk);
        wait_idle(400);
        chk_rx("t3_rx0", 8'h5A);
        chk_rx("t3_rx1", 8'h0F);

        // 4: watchdog abort with tx_done stuck low
        do_reset();
        tie0 = 1'b1;
        bus.req_data = 32'h77009900;
        bus.req = 4'b1000;
        @(negedge clk);
        chk("t4_gnt", 32'(bus.gnt), 32'h8);
        bus.req[1] = 1'b1;
        n = 0;
        while (bus.err !== 1'b1 && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_err_time", 32'(n), TO);
        chk("t4_newd", 32'(bus.tx_newd), 0);
        chk("t4_noack", 32'(ack_cnt[3]), 0);
        bus.req[3] = 1'b0;
        tie0 = 1'b0;
        n = 0;
        while (bus.gnt !== 4'b0010 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_gap_time", 32'(n), GAPC + 1);
        wait_ack(1, 3000);
        bus.req = '0;
        @(negedge clk);
        wait_idle(400);
        chk("t4_errcnt", 32'(err_cnt), 1);
        chk_rx("t4_rx0", 8'h77);
        chk_rx("t4_rx1", 8'h99);

        // 5: reset in the middle of SEND
        do_reset();
        bus.req_data = 32'h00000055;
        bus.req = 4'b0001;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        chk("t5_gnt",  32'(bus.gnt), 0);
        chk("t5_newd", 32'(bus.tx_newd), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        wait_tx_idle(3000);
        repeat (2) @(negedge clk);
        chk("t5_noack", 32'(ack_cnt[0]), 0);
        chk("t5_noerr", 32'(err_cnt), 0);
        chk("t5_idle",  32'(bus.busy), 0);
        rx_q.delete();
        bus.req_data = 32'h0000003C;
        bus.req = 4'b0001;
        wait_ack(0, 3000);
        bus.req = '0;
        @(negedge clk);
        wait_idle(400);
        chk_rx("t5_rx", 8'h3C);

        // 6: one client streaming three bytes
        do_reset();
        bus.req_data = 32'h00000000;
        bus.req = 4'b0001;
        wait_ack(0, 3000);
        bus.req_data[7:0] = 8'hFF;
        wait_ack(0, 3000);
        bus.req_data[7:0] = 8'h81;
        wait_ack(0, 3000);
        bus.req = '0;
        repeat (1500) @(negedge clk);
        chk("t6_sends", 32'(sends), 3);
        chk("t6_acks",  32'(ack_cnt[0]), 3);
        chk("t6_rxn",   32'(rx_q.size()), 3);
        chk_rx("t6_rx0", 8'h00);
        chk_rx("t6_rx1", 8'hFF);
        chk_rx("t6_rx2", 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
